// File: rtl/gate_truth_table_checker.sv
// Truth-table sequencer: walks every N-bit vector into an external gate,
// holds each one for HOLD cycles and checks the gate output against a
// selectable golden function. It keeps the mismatch count and the first
// failing vector.
module gate_truth_table_checker #(
  parameter int unsigned N    = 2,
  parameter int unsigned HOLD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic         dut_f,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic         fail_seen
);

  localparam int unsigned TW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD - 1);
  localparam logic [N-1:0]  VEC_LAST   = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    mode_q;
  logic [TW-1:0] timer;
  logic          golden;
  logic          sample;
  logic          mismatch;

  // Golden output of the selected reference function for the current vector
  always_comb begin
    golden = 1'b0;
    case (mode_q)
      3'd0:    golden = &vec;
      3'd1:    golden = |vec;
      3'd2:    golden = ~(&vec);
      3'd3:    golden = ~(|vec);
      3'd4:    golden = ^vec;
      3'd5:    golden = ~(^vec);
      3'd6:    golden = vec[0];
      3'd7:    golden = ~vec[0];
      default: golden = 1'b0;
    endcase
  end

  assign sample   = (timer == TIMER_LAST);
  assign mismatch = (golden != dut_f);

  // Pass is derived from registered state, so it never glitches high mid-run
  assign pass = done & (err_count == '0);

  // Sequencer FSM: vector walk, hold timer, mismatch bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 3'd0;
      timer      <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            mode_q     <= mode;
            timer      <= '0;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
          end
        end
        RUN: begin
          if (sample) begin
            timer <= '0;
            if (mismatch) begin
              // At most 2^N mismatches per run, so N+1 bits never overflow
              err_count <= err_count + (N+1)'(1);
              if (!fail_seen) begin
                fail_seen  <= 1'b1;
                first_fail <= vec;
              end
            end
            if (vec == VEC_LAST) begin
              state <= DONE;
              vec   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec <= vec + N'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: a table of per-mode runs on an
// N=2/HOLD=10 instance plus hand sequences for reset, mode changes and
// back-to-back runs on an N=3/HOLD=1 instance.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst;

  // Instance A: N=2, HOLD=10
  logic       start_a;
  logic [2:0] mode_a;
  logic       dut_f_a;
  logic [1:0] vec_a;
  logic       busy_a, done_a, pass_a, fail_seen_a;
  logic [2:0] err_a;
  logic [1:0] first_a;
  int         mdl_a;

  // Instance B: N=3, HOLD=1
  logic       start_b;
  logic [2:0] mode_b;
  logic       dut_f_b;
  logic [2:0] vec_b;
  logic       busy_b, done_b, pass_b, fail_seen_b;
  logic [3:0] err_b;
  logic [2:0] first_b;
  logic       inv_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate models: A is a NOR (mdl 0) or stuck at 0 (mdl 1); B is XOR, optionally inverted
  assign dut_f_a = (mdl_a == 0) ? ~(|vec_a) : 1'b0;
  assign dut_f_b = (^vec_b) ^ inv_b;

  gate_truth_table_checker #(.N(2), .HOLD(10)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .dut_f(dut_f_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(first_a), .fail_seen(fail_seen_a)
  );

  gate_truth_table_checker #(.N(3), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .dut_f(dut_f_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(first_b), .fail_seen(fail_seen_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic gold(input logic [2:0] m, input logic [1:0] v);
    case (m)
      3'd0: return &v;
      3'd1: return |v;
      3'd2: return ~(&v);
      3'd3: return ~(|v);
      3'd4: return ^v;
      3'd5: return ~(^v);
      3'd6: return v[0];
      default: return ~v[0];
    endcase
  endfunction

  function automatic logic model_a(input int mdl, input logic [1:0] v);
    return (mdl == 0) ? ~(|v) : 1'b0;
  endfunction

  // Full run on A; optionally pokes start/mode at cycle poke_j of the run
  task automatic run_a(input logic [2:0] m, input int mdl, input int poke_j,
                       input logic [2:0] poke_m);
    int exp_err;
    exp_err = 0;
    @(negedge clk);
    mode_a = m;
    mdl_a = mdl;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int j = 0; j <= 40; j++) begin
      if (j < 40) begin
        chk("a_busy_run", busy_a, 1);
        chk("a_done_run", done_a, 0);
        chk("a_vec_walk", vec_a, j / 10);
      end else begin
        chk("a_done_end", done_a, 1);
        chk("a_busy_end", busy_a, 0);
        chk("a_vec_end", vec_a, 0);
      end
      chk("a_err_track", err_a, exp_err);
      if ((j % 10) == 9 && j < 40)
        if (gold(m, 2'(j / 10)) != model_a(mdl, 2'(j / 10))) exp_err++;
      if (j == poke_j) begin
        mode_a = poke_m;
        start_a = 1'b1;
      end
      if (j == poke_j + 1) start_a = 1'b0;
      if (j < 40) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0] mode;
    int         mdl;
    int         err;
    logic [1:0] first;
    logic       fs;
    logic       pass;
  } row_t;

  row_t tbl[10];

  initial begin
    // mode, model, expected err_count, first_fail, fail_seen, pass
    tbl[0] = '{3'd3, 0, 0, 2'b00, 1'b0, 1'b1};  // NOR vs NOR
    tbl[1] = '{3'd0, 0, 2, 2'b00, 1'b1, 1'b0};  // AND: 00, 11 fail
    tbl[2] = '{3'd1, 0, 4, 2'b00, 1'b1, 1'b0};  // OR: all fail
    tbl[3] = '{3'd2, 0, 2, 2'b01, 1'b1, 1'b0};  // NAND: 01, 10 fail
    tbl[4] = '{3'd4, 0, 3, 2'b00, 1'b1, 1'b0};  // XOR: 00, 01, 10 fail
    tbl[5] = '{3'd5, 0, 1, 2'b11, 1'b1, 1'b0};  // XNOR: 11 fails
    tbl[6] = '{3'd6, 0, 3, 2'b00, 1'b1, 1'b0};  // BUF: 00, 01, 11 fail
    tbl[7] = '{3'd7, 0, 1, 2'b10, 1'b1, 1'b0};  // NOT: 10 fails
    tbl[8] = '{3'd3, 1, 1, 2'b00, 1'b1, 1'b0};  // tied 0 vs NOR: 00 fails
    tbl[9] = '{3'd0, 1, 1, 2'b11, 1'b1, 1'b0};  // tied 0 vs AND: 11 fails

    rst = 1'b1;
    start_a = 1'b0; mode_a = 3'd0; mdl_a = 0;
    start_b = 1'b0; mode_b = 3'd4; inv_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_a_vec", vec_a, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_done", done_a, 0);
    chk("rst_a_pass", pass_a, 0);
    chk("rst_a_err", err_a, 0);
    chk("rst_a_first", first_a, 0);
    chk("rst_a_fs", fail_seen_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_done", done_b, 0);
    rst = 1'b0;

    // Table-driven runs over every golden mode
    for (int i = 0; i < 10; i++) begin
      run_a(tbl[i].mode, tbl[i].mdl, -1, 3'd0);
      chk("tbl_err", err_a, tbl[i].err);
      chk("tbl_first", first_a, tbl[i].first);
      chk("tbl_fs", fail_seen_a, tbl[i].fs);
      chk("tbl_pass", pass_a, tbl[i].pass);
    end

    // Mid-run asynchronous reset, then a clean full run
    @(negedge clk);
    mode_a = 3'd3; mdl_a = 1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_err_pre", err_a, 1);
    chk("mid_vec_pre", vec_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vec", vec_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_err", err_a, 0);
    chk("mid_rst_fs", fail_seen_a, 0);
    chk("mid_rst_first", first_a, 0);
    chk("mid_rst_pass", pass_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy_a, 0);
    run_a(3'd3, 0, -1, 3'd0);
    chk("post_rst_err", err_a, 0);
    chk("post_rst_pass", pass_a, 1);

    // Start/mode poke during a run is ignored; new mode applies on re-run
    run_a(3'd3, 0, 5, 3'd0);
    chk("poke_err", err_a, 0);
    chk("poke_pass", pass_a, 1);
    run_a(3'd0, 0, -1, 3'd0);
    chk("newmode_err", err_a, 2);
    chk("newmode_first", first_a, 0);
    chk("newmode_pass", pass_a, 0);

    // B: XOR, HOLD=1, done exactly 8 cycles after the start edge
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      chk("b_done_timing", done_b, (j == 8) ? 1 : 0);
      chk("b_busy_timing", busy_b, (j == 8) ? 0 : 1);
      chk("b_vec_walk", vec_b, (j == 8) ? 0 : j);
      if (j < 8) @(negedge clk);
    end
    chk("b_err", err_b, 0);
    chk("b_pass", pass_b, 1);
    chk("b_fs", fail_seen_b, 0);

    // B inverted: every vector fails
    inv_b = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (8) @(negedge clk);
    chk("binv_done", done_b, 1);
    chk("binv_err", err_b, 8);
    chk("binv_first", first_b, 0);
    chk("binv_fs", fail_seen_b, 1);
    chk("binv_pass", pass_b, 0);

    // B with start held high: done lasts one cycle, then an immediate re-run
    inv_b = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    for (int j = 0; j <= 17; j++) begin
      chk("hold_done", done_b, (j == 8 || j == 17) ? 1 : 0);
      chk("hold_busy", busy_b, (j == 8 || j == 17) ? 0 : 1);
      if (j == 9) start_b = 1'b0;
      if (j < 17) @(negedge clk);
    end
    chk("hold_pass", pass_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
# gate_truth_table_checker

Parametrised, self-checking truth-table sequencer for the basic-gate library. It drives every combination of an N-bit input vector into an external gate under test, holding each vector for HOLD cycles, and compares the gate output against a selectable golden function. It accumulates the mismatch count and records the first failing vector, so gate checks run in-fabric or as a reusable bench component instead of hand-written per-gate vector lists.

## Interface
Parameters:
- N, default 2: width of the stimulus vector; legal range 1..16.
- HOLD, default 10: cycles each vector is held before its sample; legal minimum 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- mode  input  3  golden function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR (all reductions over vec), 6 BUF vec[0], 7 NOT vec[0].
- dut_f  input  1  output of the gate under test; must be stable by the sample edge; not synchronised here.
- vec  output  N  stimulus vector to the gate under test.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; stays high until the next start or rst.
- pass  output  1  valid while done: 1 when err_count == 0.
- err_count  output  N+1  number of mismatching vectors in the current or last run.
- first_fail  output  N  vector value of the first mismatch; valid when fail_seen.
- fail_seen  output  1  at least one mismatch in the current or last run.

## Operation
- FSM states: IDLE, RUN, DONE. There is no other state.
- IDLE -> RUN on start. This transition latches mode into mode_q and clears vec, timer, err_count, fail_seen and first_fail.
- DONE -> RUN on start, with the identical clearing; this is a re-run. DONE with no start stays in DONE.
- RUN ignores start. Changes on mode during RUN have no effect.
- The timer counts 0..HOLD-1 within RUN. A sample edge is any edge where timer == HOLD-1.
- At a sample edge:
  - Compute golden = f(mode_q, vec) combinationally and compare it with dut_f.
  - On mismatch, increment err_count.
  - On the first mismatch of a run, set fail_seen = 1 and first_fail = vec.
  - If vec is all ones, go to DONE and set vec to 0. Otherwise vec = vec + 1 and timer = 0.
- vec walks in ascending binary order, 0 .. 2^N-1, and never wraps within a run.
- err_count saturates by construction: its maximum is 2^N, which fits in N+1 bits.
- pass = done & (err_count == 0). It is combinational from registered state.
- For N = 1, the reduction modes reduce a single bit: AND, OR and XOR all equal vec[0].

## Timing
- Reset values: state IDLE, vec 0, busy 0, done 0, pass 0, err_count 0, first_fail 0, fail_seen 0, timer 0.
- rst is asynchronous. Asserting it mid-run forces all reset values immediately; the run is abandoned with no partial done.
- Start accepted at edge t:
  - from t+, busy = 1 and vec = 0;
  - vector k is driven on cycles t+k·HOLD .. t+(k+1)·HOLD-1;
  - vector k is sampled at edge t+(k+1)·HOLD.
- Run length: done rises after edge t + 2^N·HOLD, and busy falls in the same cycle. There is no gap between the last sample and DONE.
- err_count, fail_seen and first_fail update at the sample edge itself, so they are visible the cycle after the sample.
- A mismatch on the last vector is counted before done rises. pass is therefore never transiently 1 for a failing run.
- start held high continuously starts exactly one run from IDLE. On reaching DONE it immediately re-runs, and done is high for one cycle only.

## Test plan
- NOR model on vec, N=2, HOLD=10, mode=3, pulse start -> vec steps 00, 01, 10, 11 at 10-cycle intervals; done after 40 cycles; err_count=0, pass=1, fail_seen=0.
- NOR model, mode=0 (AND), N=2 -> mismatches at 00 and 11 only; err_count=2, first_fail=00, pass=0.
- dut_f tied 0, mode=3, N=2 -> only vector 00 fails; err_count=1, first_fail=00.
- XOR model, N=3, HOLD=1, mode=4 -> done exactly 8 cycles after the start edge; pass=1. Repeat with dut_f inverted -> err_count=8, first_fail=000.
- Assert rst 15 cycles into the N=2, HOLD=10 run -> all outputs return to reset values immediately. A fresh start gives a full 40-cycle run with a correct result.
- Pulse start and change mode at cycle 5 of a run -> no restart and the latched mode is kept. After done, start with a new mode -> the counters clear and the new run is checked against the new mode.
